cabac_level_rate_est: RTL
=========================

# cabac_level_rate_est

Parametrised successor to the single-cycle context bit lookup for the RDOQ CABAC bit-rate estimator. It computes the fractional bit cost of one candidate absolute level. The cost covers the greater1 and greater2 bins plus the Golomb-Rice/Exp-Golomb escape suffix. The block owns the per-coefficient-group context state (c1, c1Idx, c2Idx, Rice parameter) and updates it only for committed candidates, so RDOQ can evaluate several levels per coefficient before choosing one.

## Interface
- COST_W, 16: width of each input context cost (fixed point, FRAC_W fraction bits).
- FRAC_W, 15: fraction bits; one whole bit = 1<<FRAC_W.
- LEVEL_W, 16: candidate level width.
- ACC_W, 32: output bit-cost width.
- C1_LIMIT, 8: maximum greater1 flags per CG.
- C2_LIMIT, 1: maximum greater2 flags per CG.
- MAX_RICE, 4: Rice parameter ceiling.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  candidate valid.
- in_ready  out  1  block can accept.
- in_level  in  LEVEL_W  candidate absolute level.
- in_commit  in  1  update context state with this level.
- in_cg_start  in  1  reinitialise CG state before evaluating this beat.
- in_cg_last  in  1  last coefficient of CG (used by CG accumulator).
- in_g1_cost0, in_g1_cost1  in  COST_W  greater1 cost for bin 0 / bin 1.
- in_g2_cost0, in_g2_cost1  in  COST_W  greater2 cost for bin 0 / bin 1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_bits  out  ACC_W  bit cost of the candidate.
- out_c1  out  2  current c1 context state.
- out_c1_idx  out  $clog2(C1_LIMIT+1)  greater1 count.
- out_c2_idx  out  $clog2(C2_LIMIT+1)  greater2 count.
- out_rice  out  $clog2(MAX_RICE+1)  current Rice parameter.
- cg_bits  out  ACC_W  committed CG total (config-dependent).
- cg_bits_valid  out  1  one-cycle pulse with cg_bits.

## Operation
- The FSM has four states: IDLE, CALC, ESC and OUT.
- In IDLE, in_ready=1. On in_valid&&in_ready the block registers all inputs and moves to CALC.
- If in_cg_start is set, the working state is c1=1, c1Idx=0, c2Idx=0, rice=0. Otherwise the stored state is used.
- g1ok = c1Idx<C1_LIMIT; g2ok = g1ok && c2Idx<C2_LIMIT; base = g1ok ? (g2ok ? 3 : 2) : 1.
- CALC computes the cost by level:
  - level 0: 0.
  - level < base: level 1 gives g1_cost0. Level 2 gives g1_cost1+g2_cost0.
  - level >= base: cost = (g1ok ? g1_cost1 : 0) + (g2ok ? g2_cost1 : 0) + escape(s=level-base, k=rice).
- Escape, prefix-only case: if s < (3<<k), escape = ((s>>k)+1+k)<<FRAC_W. This is computed in CALC, then CALC→OUT.
- Escape, Exp-Golomb case: otherwise CALC loads s'=s-(3<<k), len=k and goes to ESC.
  - In ESC, each cycle: if s' >= (1<<len), then s' -= 1<<len and len++. Otherwise escape = (4+2*len-k)<<FRAC_W, then ESC→OUT.
- Costs are zero-extended to ACC_W. The sum saturates at all-ones.
- In OUT, out_valid=1 and out_bits is held stable until out_ready. On the handshake the FSM returns to IDLE. If in_commit is set, the context state is updated as below.
- Context update applies to committed nonzero levels only; level 0 leaves the state unchanged (except the in_cg_start init):
  - level>1 gives c1=0. Level==1 with 0<c1<3 gives c1++.
  - if g1ok, c1Idx++. If level>1 && g2ok, c2Idx++.
  - if level > (3<<rice), rice=min(rice+1, MAX_RICE).
- Uncommitted beats never modify the stored state. An in_cg_start on an uncommitted beat is evaluated but not stored.
- out_c1, out_c1_idx, out_c2_idx and out_rice always show the stored state.

## Timing
- Reset values: in_ready=1 (asserted in IDLE), out_valid=0, out_bits=0, out_c1=1, out_c1_idx=0, out_c2_idx=0, out_rice=0, cg_bits=0, cg_bits_valid=0. The FSM resets to IDLE.
- Latency: accept edge T. Without the ESC path, out_valid is high after edge T+2.
- With ESC: out_valid is high after edge T+2+E, where E = final len - k + 1.
- Throughput is one beat per result. in_ready=0 in CALC, ESC and OUT.
- An out_ready held low stalls indefinitely with outputs stable.
- Reset asserted mid-CALC/ESC/OUT aborts the beat. No result is produced and no state is updated.

## Configuration
- CABAC_RATE_CG_ACC_EN defined: a CG accumulator is compiled in.
  - It adds out_bits of committed beats; it is cleared on committed in_cg_start before adding.
  - On the handshake of a committed beat with in_cg_last, cg_bits = the total and cg_bits_valid pulses for 1 cycle.
  - The accumulator saturates at all-ones.
- CABAC_RATE_CG_ACC_EN undefined: cg_bits=0 and cg_bits_valid=0 constantly. No accumulator logic is present.

## Test plan
- cg_start, level 1, g1_cost0=0x1000, commit -> out_bits=0x1000 at T+2; out_c1=2, out_c1_idx=1.
- After the previous beat, level 2, g1_cost1=0x2000, g2_cost0=0x0800, commit=0 -> out_bits=0x2800; out_c1 and out_c2_idx are unchanged.
- cg_start, level 3, g1_cost1=0x2000, g2_cost1=0x0C00 (s=0, k=0) -> out_bits=0xAC00.
- 8 committed level-1 beats, then level 10 committed (base 1, s=9, EG path) -> E=3, out_bits=0x40000 at T+5; out_rice=1 afterwards.
- out_ready low 4 cycles in OUT -> out_valid and out_bits stable, in_ready=0; the handshake on the 5th cycle returns the FSM to IDLE.
- rst_n pulsed during ESC -> all outputs at reset values, stored state = init. With CABAC_RATE_CG_ACC_EN: costs 0x1000+0x2800 committed, the second with in_cg_last -> cg_bits=0x3800, one-cycle cg_bits_valid.

Source files
------------

// File: rtl/cabac_level_rate_est.sv
`default_nettype none
// ============================================================================
// Module   : cabac_level_rate_est
// Purpose  : RDOQ rate estimate of one candidate level (greater1/greater2 bins
//            plus Rice/Exp-Golomb escape) with per-CG context state.
//            Optional CG accumulator: define CABAC_RATE_CG_ACC_EN.
// Revision : 1.0
// ============================================================================
module cabac_level_rate_est #(
    parameter int COST_W   = 16,
    parameter int FRAC_W   = 15,
    parameter int LEVEL_W  = 16,
    parameter int ACC_W    = 32,
    parameter int C1_LIMIT = 8,
    parameter int C2_LIMIT = 1,
    parameter int MAX_RICE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LEVEL_W-1:0]            in_level,
    input  logic                          in_commit,
    input  logic                          in_cg_start,
    input  logic                          in_cg_last,
    input  logic [COST_W-1:0]             in_g1_cost0,
    input  logic [COST_W-1:0]             in_g1_cost1,
    input  logic [COST_W-1:0]             in_g2_cost0,
    input  logic [COST_W-1:0]             in_g2_cost1,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_bits,
    output logic [1:0]                    out_c1,
    output logic [$clog2(C1_LIMIT+1)-1:0] out_c1_idx,
    output logic [$clog2(C2_LIMIT+1)-1:0] out_c2_idx,
    output logic [$clog2(MAX_RICE+1)-1:0] out_rice,
    output logic [ACC_W-1:0]              cg_bits,
    output logic                          cg_bits_valid
);
    localparam int C1I_W  = $clog2(C1_LIMIT+1);
    localparam int C2I_W  = $clog2(C2_LIMIT+1);
    localparam int RICE_W = $clog2(MAX_RICE+1);
    localparam int FX_W   = COST_W + 1;
    localparam int S_W    = LEVEL_W + 2;
    localparam int LEN_W  = $clog2(S_W) + 1;
    localparam int EXT_W  = ((ACC_W > FRAC_W + 8) ? ACC_W : FRAC_W + 8) + 2;
    localparam logic [C1I_W-1:0]  C_C1_LIM   = C1I_W'(C1_LIMIT);
    localparam logic [C2I_W-1:0]  C_C2_LIM   = C2I_W'(C2_LIMIT);
    localparam logic [RICE_W-1:0] C_MAX_RICE = RICE_W'(MAX_RICE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ESC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_ph;
    logic [LEVEL_W-1:0]   r_level;
    logic                 r_commit;
    logic                 r_cg_start;
    logic                 r_cg_last;
    logic [COST_W-1:0]    r_g1c0, r_g1c1, r_g2c0, r_g2c1;
    logic [FX_W-1:0]      r_fixed;
    logic                 r_esc;
    logic [S_W-1:0]       r_s;
    logic [RICE_W-1:0]    r_k;
    logic [S_W-1:0]       r_sp;
    logic [LEN_W-1:0]     r_len;

    logic [1:0]           r_c1;
    logic [C1I_W-1:0]     r_c1_idx;
    logic [C2I_W-1:0]     r_c2_idx;
    logic [RICE_W-1:0]    r_rice;

    assign out_c1     = r_c1;
    assign out_c1_idx = r_c1_idx;
    assign out_c2_idx = r_c2_idx;
    assign out_rice   = r_rice;

    // Working context: a CG start replaces the stored state for this beat only.
    logic [1:0]        w_c1;
    logic [C1I_W-1:0]  w_c1_idx;
    logic [C2I_W-1:0]  w_c2_idx;
    logic [RICE_W-1:0] w_rice;
    logic              w_g1ok, w_g2ok, w_esc_need;
    logic [1:0]        w_base;
    logic [S_W-1:0]    w_lvl_ext, w_s;

    assign w_c1       = r_cg_start ? 2'd1 : r_c1;
    assign w_c1_idx   = r_cg_start ? '0 : r_c1_idx;
    assign w_c2_idx   = r_cg_start ? '0 : r_c2_idx;
    assign w_rice     = r_cg_start ? '0 : r_rice;
    assign w_g1ok     = (w_c1_idx < C_C1_LIM);
    assign w_g2ok     = w_g1ok && (w_c2_idx < C_C2_LIM);
    assign w_base     = w_g1ok ? (w_g2ok ? 2'd3 : 2'd2) : 2'd1;
    assign w_lvl_ext  = S_W'(r_level);
    assign w_esc_need = (w_lvl_ext >= S_W'(w_base));
    assign w_s        = w_lvl_ext - S_W'(w_base);

    logic [FX_W-1:0] w_fixed;
    always_comb begin
        w_fixed = '0;
        if (r_level == '0) begin
            w_fixed = '0;
        end else if (!w_esc_need) begin
            if (r_level == LEVEL_W'(1))
                w_fixed = FX_W'(r_g1c0);
            else
                w_fixed = FX_W'(r_g1c1) + FX_W'(r_g2c0);
        end else begin
            w_fixed = (w_g1ok ? FX_W'(r_g1c1) : '0) + (w_g2ok ? FX_W'(r_g2c1) : '0);
        end
    end

    logic [S_W-1:0]   w_thr, w_pow;
    logic [EXT_W-1:0] w_pre, w_eg;
    assign w_thr = S_W'(3) << r_k;
    assign w_pow = S_W'(1) << r_len;
    assign w_pre = (EXT_W'(r_s >> r_k) + EXT_W'(r_k) + EXT_W'(1)) << FRAC_W;
    assign w_eg  = (EXT_W'(4) + (EXT_W'(r_len) << 1) - EXT_W'(r_k)) << FRAC_W;

    function automatic logic [ACC_W-1:0] f_sat(input logic [EXT_W-1:0] v);
        f_sat = (|v[EXT_W-1:ACC_W]) ? '1 : v[ACC_W-1:0];
    endfunction

    logic [1:0]        w_nc1;
    logic [C1I_W-1:0]  w_nc1_idx;
    logic [C2I_W-1:0]  w_nc2_idx;
    logic [RICE_W-1:0] w_nrice;
    always_comb begin
        w_nc1     = w_c1;
        w_nc1_idx = w_c1_idx;
        w_nc2_idx = w_c2_idx;
        w_nrice   = w_rice;
        if (r_level != '0) begin
            if (r_level > LEVEL_W'(1))
                w_nc1 = 2'd0;
            else if (w_c1 != 2'd0 && w_c1 != 2'd3)
                w_nc1 = w_c1 + 2'd1;
            if (w_g1ok)
                w_nc1_idx = w_c1_idx + C1I_W'(1);
            if (r_level > LEVEL_W'(1) && w_g2ok)
                w_nc2_idx = w_c2_idx + C2I_W'(1);
            if (w_lvl_ext > (S_W'(3) << w_rice) && w_rice < C_MAX_RICE)
                w_nrice = w_rice + RICE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ph       <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_bits   <= '0;
            r_level    <= '0;
            r_commit   <= 1'b0;
            r_cg_start <= 1'b0;
            r_cg_last  <= 1'b0;
            r_g1c0     <= '0;
            r_g1c1     <= '0;
            r_g2c0     <= '0;
            r_g2c1     <= '0;
            r_fixed    <= '0;
            r_esc      <= 1'b0;
            r_s        <= '0;
            r_k        <= '0;
            r_sp       <= '0;
            r_len      <= '0;
            r_c1       <= 2'd1;
            r_c1_idx   <= '0;
            r_c2_idx   <= '0;
            r_rice     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_level    <= in_level;
                        r_commit   <= in_commit;
                        r_cg_start <= in_cg_start;
                        r_cg_last  <= in_cg_last;
                        r_g1c0     <= in_g1_cost0;
                        r_g1c1     <= in_g1_cost1;
                        r_g2c0     <= in_g2_cost0;
                        r_g2c1     <= in_g2_cost1;
                        r_ph       <= 1'b0;
                        in_ready   <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    // First cycle resolves context/bins, second classifies the escape.
                    if (!r_ph) begin
                        r_fixed <= w_fixed;
                        r_esc   <= w_esc_need;
                        r_s     <= w_s;
                        r_k     <= w_rice;
                        r_ph    <= 1'b1;
                    end else if (!r_esc) begin
                        out_bits  <= f_sat(EXT_W'(r_fixed));
                        out_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end else if (r_s < w_thr) begin
                        out_bits  <= f_sat(EXT_W'(r_fixed) + w_pre);
                        out_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end else begin
                        r_sp    <= r_s - w_thr;
                        r_len   <= LEN_W'(r_k);
                        r_state <= S_ESC;
                    end
                end
                S_ESC: begin
                    if (r_sp >= w_pow) begin
                        r_sp  <= r_sp - w_pow;
                        r_len <= r_len + LEN_W'(1);
                    end else begin
                        out_bits  <= f_sat(EXT_W'(r_fixed) + w_eg);
                        out_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                        if (r_commit) begin
                            r_c1     <= w_nc1;
                            r_c1_idx <= w_nc1_idx;
                            r_c2_idx <= w_nc2_idx;
                            r_rice   <= w_nrice;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CABAC_RATE_CG_ACC_EN
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W:0]   w_acc_sum;
    logic [ACC_W-1:0] w_acc_sat;
    assign w_acc_base = r_cg_start ? '0 : r_acc;
    assign w_acc_sum  = {1'b0, w_acc_base} + {1'b0, out_bits};
    assign w_acc_sat  = w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            cg_bits       <= '0;
            cg_bits_valid <= 1'b0;
        end else begin
            cg_bits_valid <= 1'b0;
            if (r_state == S_OUT && out_ready && r_commit) begin
                r_acc <= w_acc_sat;
                if (r_cg_last) begin
                    cg_bits       <= w_acc_sat;
                    cg_bits_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_cg_last;
    assign w_unused_cg_last = r_cg_last;
    assign cg_bits          = '0;
    assign cg_bits_valid    = 1'b0;
`endif

endmodule
`default_nettype wire
